activation_interp_sequencer: RTL and testbench



---
 rtl/activation_interp_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_activation_interp_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/activation_interp_sequencer.sv
// -----------------------------------------------------------------------------
// activation_interp_sequencer
//
// Pushes a vector of signed fixed-point pre-activations, one element at a time,
// through a single shared piecewise-linear activation interpolator. For each
// element the two neighbouring lookup entries (base, next) are fetched from a
// synchronous ROM with one-cycle read latency. The interpolator is then driven
// with base/next/fraction, and its combinational result is written into the
// matching slot of the output vector.
//
// Per element: RB -> RN -> CN -> IP (4 cycles). Per vector: + IDLE accept + DONE.
//
// Ports
//   clk              rising-edge clock
//   rst              synchronous active-high reset
//   start_i          one-cycle request, honoured only in IDLE
//   in_vec_i         N_NEURONS packed elements, element i at [i*WIDTH +: WIDTH]
//   busy_o           high from the cycle after acceptance through DONE
//   done_o           one-cycle pulse; out_vec_o valid until the next acceptance
//   out_vec_o        activations, same packing as in_vec_i
//   rom_addr_o       ROM read address (holds between reads)
//   rom_data_i       ROM data, valid one cycle after its address
//   itp_base_o       interpolator lower entry
//   itp_next_o       interpolator upper entry
//   itp_remaining_o  interpolator fraction, zero-extended to WIDTH
//   itp_value_i      interpolator result (combinational from itp_*_o)
// -----------------------------------------------------------------------------
module activation_interp_sequencer #(
  parameter int N_NEURONS = 2,
  parameter int WIDTH     = 8,
  parameter int FRAC      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic [N_NEURONS*WIDTH-1:0]  in_vec_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [N_NEURONS*WIDTH-1:0]  out_vec_o,
  output logic [WIDTH-FRAC-1:0]       rom_addr_o,
  input  logic [WIDTH-1:0]            rom_data_i,
  output logic [WIDTH-1:0]            itp_base_o,
  output logic [WIDTH-1:0]            itp_next_o,
  output logic [WIDTH-1:0]            itp_remaining_o,
  input  logic [WIDTH-1:0]            itp_value_i
);

  localparam int AW = WIDTH - FRAC;
  localparam int IW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

  // Adding 2^(AW-1) to the signed integer part is the same as flipping its MSB.
  localparam logic [AW-1:0] ADDR_BIAS = AW'(1) << (AW - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_NEURONS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RB,    // present base address
    S_RN,    // capture base entry, present next address
    S_CN,    // capture next entry, load interpolator operands
    S_IP,    // interpolator result valid, write slot
    S_DONE
  } state_e;

  state_e                       state_q, state_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [N_NEURONS*WIDTH-1:0]   vec_q, vec_d;
  logic [WIDTH-1:0]             base_q, base_d;
  logic [N_NEURONS*WIDTH-1:0]   out_q, out_d;
  logic [AW-1:0]                addr_q, addr_d;
  logic [WIDTH-1:0]             itp_base_q, itp_base_d;
  logic [WIDTH-1:0]             itp_next_q, itp_next_d;
  logic [WIDTH-1:0]             itp_rem_q, itp_rem_d;

  // Decode of the element currently being processed.
  int                           slot;
  logic [WIDTH-1:0]             cur_x;
  logic [AW-1:0]                base_addr;
  logic [AW-1:0]                next_addr;
  logic [WIDTH-1:0]             cur_rem;

  always_comb begin
    slot      = int'(idx_q) * WIDTH;
    cur_x     = vec_q[slot +: WIDTH];
    base_addr = cur_x[WIDTH-1:FRAC] ^ ADDR_BIAS;
    // The top entry has no upper neighbour: reuse it instead of wrapping to 0.
    next_addr = (&base_addr) ? base_addr : base_addr + AW'(1);
    cur_rem   = WIDTH'(cur_x[FRAC-1:0]);
  end

  // Next-state and datapath.
  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the
    // case can leave one unassigned and infer a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    vec_d      = vec_q;
    base_d     = base_q;
    out_d      = out_q;
    addr_d     = addr_q;
    itp_base_d = itp_base_q;
    itp_next_d = itp_next_q;
    itp_rem_d  = itp_rem_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          vec_d   = in_vec_i;
          idx_d   = '0;
          state_d = S_RB;
        end
      end
      S_RB: begin
        addr_d  = base_addr;
        state_d = S_RN;
      end
      S_RN: begin
        base_d  = rom_data_i;
        addr_d  = next_addr;
        state_d = S_CN;
      end
      S_CN: begin
        // Operands are registered here so they are stable for the whole IP cycle.
        itp_base_d = base_q;
        itp_next_d = rom_data_i;
        itp_rem_d  = cur_rem;
        state_d    = S_IP;
      end
      S_IP: begin
        out_d[slot +: WIDTH] = itp_value_i;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = S_RB;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and visible state: all reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks, so every register
    // samples the pre-edge value of every other register.
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      out_q      <= '0;
      addr_q     <= '0;
      itp_base_q <= '0;
      itp_next_q <= '0;
      itp_rem_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      out_q      <= out_d;
      addr_q     <= addr_d;
      itp_base_q <= itp_base_d;
      itp_next_q <= itp_next_d;
      itp_rem_q  <= itp_rem_d;
    end
  end

  // NOTE: the latched input vector and base entry are pure data, always written
  // before they are read, so they carry no reset.
  always_ff @(posedge clk) begin
    vec_q  <= vec_d;
    base_q <= base_d;
  end

  // The address is driven straight from the decode in RB/RN so the ROM sees it
  // in the same cycle; elsewhere the last address is held.
  assign rom_addr_o      = addr_d;
  assign busy_o          = (state_q != S_IDLE);
  assign done_o          = (state_q == S_DONE);
  assign out_vec_o       = out_q;
  assign itp_base_o      = itp_base_q;
  assign itp_next_o      = itp_next_q;
  assign itp_remaining_o = itp_rem_q;

endmodule

// File: tb/tb_activation_interp_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for activation_interp_sequencer. Three instances (N_NEURONS = 2, 4
// and 1) share the clock, reset and a ROM table. Each has a synchronous ROM
// model and a behavioural interpolator. Expected values come from the
// arithmetic decode of each element, the ROM table and the interpolation
// formula.
// -----------------------------------------------------------------------------
module tb_activation_interp_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          sel = 0;
  logic        start = 1'b0;
  logic [31:0] in_vec = '0;
  logic [7:0]  rom_tbl [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // ---------------- reference arithmetic ----------------
  function automatic logic [7:0] interp(input logic [7:0] b, input logic [7:0] n,
                                        input logic [7:0] r);
    int bi, ni, d;
    bi = int'($signed(b));
    ni = int'($signed(n));
    d  = (ni - bi) * int'(r);
    return 8'(bi + (d >>> 4));
  endfunction

  function automatic int base_idx(input logic [7:0] x);
    return (int'($signed(x)) >>> 4) + 8;
  endfunction

  function automatic int next_idx(input logic [7:0] x);
    return (base_idx(x) == 15) ? 15 : base_idx(x) + 1;
  endfunction

  function automatic int rem_of(input logic [7:0] x);
    return int'(x & 8'h0F);
  endfunction

  // ---------------- DUT A: N=2 ----------------
  logic        busy_a, done_a;
  logic [15:0] out_a;
  logic [3:0]  addr_a;
  logic [7:0]  rd_a, ib_a, in_a, ir_a, iv_a;
  always @(posedge clk) rd_a <= rom_tbl[addr_a];
  assign iv_a = interp(ib_a, in_a, ir_a);

  activation_interp_sequencer #(.N_NEURONS(2), .WIDTH(8), .FRAC(4)) dut_a (
    .clk(clk), .rst(rst), .start_i(start && (sel == 0)), .in_vec_i(in_vec[15:0]),
    .busy_o(busy_a), .done_o(done_a), .out_vec_o(out_a), .rom_addr_o(addr_a),
    .rom_data_i(rd_a), .itp_base_o(ib_a), .itp_next_o(in_a),
    .itp_remaining_o(ir_a), .itp_value_i(iv_a));

  // ---------------- DUT B: N=4 ----------------
  logic        busy_b, done_b;
  logic [31:0] out_b;
  logic [3:0]  addr_b;
  logic [7:0]  rd_b, ib_b, in_b, ir_b, iv_b;
  always @(posedge clk) rd_b <= rom_tbl[addr_b];
  assign iv_b = interp(ib_b, in_b, ir_b);

  activation_interp_sequencer #(.N_NEURONS(4), .WIDTH(8), .FRAC(4)) dut_b (
    .clk(clk), .rst(rst), .start_i(start && (sel == 1)), .in_vec_i(in_vec),
    .busy_o(busy_b), .done_o(done_b), .out_vec_o(out_b), .rom_addr_o(addr_b),
    .rom_data_i(rd_b), .itp_base_o(ib_b), .itp_next_o(in_b),
    .itp_remaining_o(ir_b), .itp_value_i(iv_b));

  // ---------------- DUT C: N=1 ----------------
  logic        busy_c, done_c;
  logic [7:0]  out_c;
  logic [3:0]  addr_c;
  logic [7:0]  rd_c, ib_c, in_c, ir_c, iv_c;
  always @(posedge clk) rd_c <= rom_tbl[addr_c];
  assign iv_c = interp(ib_c, in_c, ir_c);

  activation_interp_sequencer #(.N_NEURONS(1), .WIDTH(8), .FRAC(4)) dut_c (
    .clk(clk), .rst(rst), .start_i(start && (sel == 2)), .in_vec_i(in_vec[7:0]),
    .busy_o(busy_c), .done_o(done_c), .out_vec_o(out_c), .rom_addr_o(addr_c),
    .rom_data_i(rd_c), .itp_base_o(ib_c), .itp_next_o(in_c),
    .itp_remaining_o(ir_c), .itp_value_i(iv_c));

  // ---------------- observation mux ----------------
  logic        m_busy, m_done;
  logic [31:0] m_out;
  logic [3:0]  m_addr;
  logic [7:0]  m_base, m_next, m_rem;

  always_comb begin
    case (sel)
      0: begin
        m_busy = busy_a; m_done = done_a; m_out = {16'b0, out_a}; m_addr = addr_a;
        m_base = ib_a;   m_next = in_a;   m_rem = ir_a;
      end
      1: begin
        m_busy = busy_b; m_done = done_b; m_out = out_b;          m_addr = addr_b;
        m_base = ib_b;   m_next = in_b;   m_rem = ir_b;
      end
      default: begin
        m_busy = busy_c; m_done = done_c; m_out = {24'b0, out_c}; m_addr = addr_c;
        m_base = ib_c;   m_next = in_c;   m_rem = ir_c;
      end
    endcase
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (dut %0d): observed %0h expected %0h", tag, sel, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_identity_rom();
    for (int a = 0; a < 16; a++) rom_tbl[a] = 8'((a - 8) * 16);
  endtask

  // One full vector: accept in the current cycle, then walk every cycle through
  // the cycle after DONE. With pulse set, start is toggled throughout the busy
  // window (including DONE) and must be ignored. in_vec is scrambled after
  // acceptance either way.
  task automatic run_vec(input int s, input int n, input logic [31:0] v, input bit pulse);
    logic [31:0] exp_out;
    logic [7:0]  x;
    int          ba, na;
    exp_out = '0;
    na      = 0;
    sel     = s;
    start   = 1'b1;
    in_vec  = v;
    #1;
    check("accept_busy", 32'(m_busy), 0);
    for (int k = 0; k < n; k++) begin
      x = v[8*k +: 8];
      exp_out[8*k +: 8] = interp(rom_tbl[base_idx(x)], rom_tbl[next_idx(x)], 8'(rem_of(x)));
    end
    step();
    for (int k = 0; k < n; k++) begin
      x  = v[8*k +: 8];
      ba = base_idx(x);
      na = next_idx(x);
      for (int ph = 0; ph < 4; ph++) begin
        check("busy", 32'(m_busy), 1);
        check("done_early", 32'(m_done), 0);
        check(ph == 0 ? "rom_addr_base" : "rom_addr_next", 32'(m_addr), (ph == 0) ? ba : na);
        if (ph == 3) begin
          check("itp_base", 32'(m_base), 32'(rom_tbl[ba]));
          check("itp_next", 32'(m_next), 32'(rom_tbl[na]));
          check("itp_remaining", 32'(m_rem), rem_of(x));
        end
        start  = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
        in_vec = $urandom;
        step();
      end
    end
    check("done_pulse", 32'(m_done), 1);
    check("done_busy", 32'(m_busy), 1);
    check("done_out", m_out, exp_out);
    check("done_addr_hold", 32'(m_addr), na);
    start = pulse;
    step();
    start = 1'b0;
    check("after_done", 32'(m_done), 0);
    check("after_busy", 32'(m_busy), 0);
    check("after_out", m_out, exp_out);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] v;
    bit          pulse;
    int          s;
    load_identity_rom();

    // Reset state of all three instances.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      check("rst_busy", 32'(m_busy), 0);
      check("rst_done", 32'(m_done), 0);
      check("rst_out", m_out, 0);
      check("rst_addr", 32'(m_addr), 0);
      check("rst_itp_base", 32'(m_base), 0);
      check("rst_itp_next", 32'(m_next), 0);
      check("rst_itp_rem", 32'(m_rem), 0);
    end
    step();

    // Identity ROM, {0xE8, 0x18}: addresses 9,10,6,7 and output equals input.
    run_vec(0, 2, 32'h0000_E818, 1'b0);
    check("tp_identity_out", m_out, 32'h0000_E818);

    // Top entry saturates (15 then 15) and bottom entry (0 then 1), N=1.
    run_vec(2, 1, 32'h0000_007F, 1'b0);
    check("tp_top_out", m_out, 32'h0000_0070);
    run_vec(2, 1, 32'h0000_0080, 1'b0);
    check("tp_bottom_out", m_out, 32'h0000_0080);

    // Start pulses while busy and in DONE are ignored.
    run_vec(0, 2, 32'h0000_4A21, 1'b1);

    // Reset in the CN cycle of element 1 drops the vector with no done.
    sel    = 0;
    start  = 1'b1;
    in_vec = 32'h0000_3050;
    #1;
    step();
    start = 1'b0;
    repeat (6) step();
    check("mid_rst_pre_busy", 32'(m_busy), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_busy", 32'(m_busy), 0);
    check("mid_rst_done", 32'(m_done), 0);
    check("mid_rst_out", m_out, 0);
    check("mid_rst_addr", 32'(m_addr), 0);
    for (int i = 0; i < 4; i++) begin
      check("mid_rst_no_done", 32'(m_done), 0);
      step();
    end
    run_vec(0, 2, 32'h0000_C5F3, 1'b0);

    // N=4 instance: done at t+17, busy for 17 cycles.
    run_vec(1, 4, 32'h7F80_E818, 1'b0);

    // Randomized vectors and ROM contents, biased toward table edges.
    for (int it = 0; it < 40; it++) begin
      if (it % 8 == 0)
        for (int a = 0; a < 16; a++) rom_tbl[a] = 8'($urandom);
      s = $urandom_range(0, 2);
      v = $urandom;
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 3) == 0)
          v[8*b +: 8] = ($urandom_range(0, 1) == 1) ? 8'h7F : 8'h80;
      pulse = 1'($urandom_range(0, 1));
      run_vec(s, (s == 0) ? 2 : (s == 1) ? 4 : 1, v, pulse);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
